// File: rtl/rat_rename_writer.sv
// rat_rename_writer
//   Writer side of the register alias table. It renames the destination logical
//   registers (LRs) of one instruction at a time to physical registers (PRs). The
//   PRs are popped from an internal free-list FIFO. The block drives the RAT's
//   mapping and done-flag load ports. CDB broadcasts set done flags, and
//   retirement broadcasts recycle PR tags into the free list.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   rename_valid/ready/dests   decode handshake; dests has one bit per LR written
//   rename_done                one-cycle pulse when the new mapping is committed
//   cur_assignments            current RAT mapping, LR i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   cur_done_flags             current RAT done flags
//   assignments_in/valid       new mapping and its load strobe toward the RAT
//   done_flags_in/ready        new done flags and their load strobe toward the RAT
//   cdb_valid/cdb_tag          PR whose result just completed
//   retire_valid/retire_tag    PR released back to the free list
//   free_count                 number of tags currently in the free list
module rat_rename_writer #(
    parameter int NUM_LRS    = 10,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rename_valid,
    output logic                          rename_ready,
    input  logic [NUM_LRS-1:0]            rename_dests,
    output logic                          rename_done,
    input  logic [NUM_LRS*ADDR_WIDTH-1:0] cur_assignments,
    input  logic [NUM_LRS-1:0]            cur_done_flags,
    output logic [NUM_LRS*ADDR_WIDTH-1:0] assignments_in,
    output logic                          assignments_valid,
    output logic [NUM_LRS-1:0]            done_flags_in,
    output logic                          done_flags_ready,
    input  logic                          cdb_valid,
    input  logic [ADDR_WIDTH-1:0]         cdb_tag,
    input  logic                          retire_valid,
    input  logic [ADDR_WIDTH-1:0]         retire_tag,
    output logic [ADDR_WIDTH:0]           free_count
);
    localparam int NUM_PRS = 1 << ADDR_WIDTH;
    localparam int IDX_W   = (NUM_LRS > 1) ? $clog2(NUM_LRS) : 1;

    typedef logic [NUM_LRS-1:0][ADDR_WIDTH-1:0] map_t;
    typedef enum logic [1:0] {S_INIT, S_IDLE, S_ALLOC, S_COMMIT} state_t;

    state_t               state, state_nxt;
    logic [NUM_LRS-1:0]   pending, renamed;
    map_t                 working, cur_map, identity;
    logic [ADDR_WIDTH-1:0] fl_mem [NUM_PRS];
    logic [ADDR_WIDTH-1:0] head, tail;
    logic [ADDR_WIDTH:0]  count;
    logic [NUM_LRS-1:0]   alloc_oh;
    logic [IDX_W-1:0]     alloc_idx;
    logic                 found, pop, push, full;

    assign cur_map    = cur_assignments;
    assign free_count = count;

    for (genvar i = 0; i < NUM_LRS; i++) begin : g_id
        assign identity[i] = ADDR_WIDTH'(i);
    end

    function automatic logic [NUM_LRS-1:0] hit_vec(input map_t m, input logic v,
                                                   input logic [ADDR_WIDTH-1:0] t);
        logic [NUM_LRS-1:0] h;
        h = '0;
        for (int i = 0; i < NUM_LRS; i++) h[i] = v && (m[i] == t);
        return h;
    endfunction

    // Lowest pending LR gets the next free tag.
    always_comb begin
        alloc_oh  = '0;
        alloc_idx = '0;
        found     = 1'b0;
        for (int i = 0; i < NUM_LRS; i++) begin
            if (pending[i] && !found) begin
                found       = 1'b1;
                alloc_oh[i] = 1'b1;
                alloc_idx   = IDX_W'(i);
            end
        end
    end

    // A pop is decided on the registered count, so a retire arriving while the
    // list is empty becomes visible to the allocator one cycle later.
    assign full = (count == (ADDR_WIDTH+1)'(NUM_PRS));
    assign pop  = (state == S_ALLOC) && found && (count != '0);
    assign push = retire_valid && !full;

    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT:   state_nxt = S_IDLE;
            S_IDLE:   if (rename_valid) state_nxt = S_ALLOC;
            S_ALLOC:  if (!found || (pop && (pending & ~alloc_oh) == '0)) state_nxt = S_COMMIT;
            S_COMMIT: state_nxt = S_IDLE;
            default:  state_nxt = S_INIT;
        endcase
    end

    always_comb begin
        rename_ready      = 1'b0;
        rename_done       = 1'b0;
        assignments_in    = cur_assignments;
        assignments_valid = 1'b0;
        done_flags_in     = cur_done_flags | hit_vec(cur_map, cdb_valid, cdb_tag);
        done_flags_ready  = cdb_valid;
        if (!rst_n) begin
            done_flags_ready = 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    assignments_in    = identity;
                    assignments_valid = 1'b1;
                    done_flags_in     = '1;
                    done_flags_ready  = 1'b1;
                end
                S_IDLE: rename_ready = 1'b1;
                S_COMMIT: begin
                    // Newly renamed LRs are not done yet, even if a CDB hits them.
                    assignments_in    = working;
                    assignments_valid = 1'b1;
                    rename_done       = 1'b1;
                    done_flags_in     = (cur_done_flags | hit_vec(working, cdb_valid, cdb_tag))
                                        & ~renamed;
                    done_flags_ready  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_INIT;
            pending <= '0;
            renamed <= '0;
            working <= '0;
            head    <= '0;
            tail    <= ADDR_WIDTH'(NUM_PRS - NUM_LRS);
            count   <= (ADDR_WIDTH+1)'(NUM_PRS - NUM_LRS);
            // Slots past the tail hold don't-care values.
            for (int i = 0; i < NUM_PRS; i++) fl_mem[i] <= ADDR_WIDTH'(NUM_LRS + i);
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && rename_valid) begin
                pending <= rename_dests;
                renamed <= rename_dests;
                working <= cur_map;
            end
            if (pop) begin
                working[alloc_idx] <= fl_mem[head];
                pending[alloc_idx] <= 1'b0;
                head               <= head + 1'b1;
            end
            if (push) begin
                fl_mem[tail] <= retire_tag;
                tail         <= tail + 1'b1;
            end
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            assert (!(retire_valid && full))
                else $error("rat_rename_writer: retire into full free list dropped (tag %0d)", retire_tag);
        end
    end
endmodule

// File: tb/tb_rat_rename_writer.sv
module tb_rat_rename_writer;
    localparam int NL = 10, AW = 5, NP = 32;
    localparam int P_INIT = 0, P_IDLE = 1, P_ALLOC = 2, P_COMMIT = 3;
    typedef logic [NL-1:0][AW-1:0] map_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, rename_valid, rename_ready, rename_done;
    logic          assignments_valid, done_flags_ready, cdb_valid, retire_valid;
    logic [NL-1:0] rename_dests, done_flags_in;
    logic [AW-1:0] cdb_tag, retire_tag;
    logic [AW:0]   free_count;
    map_t          assignments_in;

    // RAT environment plus behavioural reference model.
    map_t          rat_map, new_map;
    logic [NL-1:0] rat_done, need, ren;
    logic [AW-1:0] fq[$];
    logic [AW-1:0] pool[$];
    int            phase;

    int            tests = 0, fails = 0;
    logic          obs_rdone, obs_av, obs_dfr;
    map_t          obs_assign;
    logic [NL-1:0] obs_dfin;
    logic [AW:0]   obs_fc;

    rat_rename_writer #(.NUM_LRS(NL), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .rename_valid(rename_valid), .rename_ready(rename_ready),
        .rename_dests(rename_dests), .rename_done(rename_done),
        .cur_assignments(rat_map), .cur_done_flags(rat_done),
        .assignments_in(assignments_in), .assignments_valid(assignments_valid),
        .done_flags_in(done_flags_in), .done_flags_ready(done_flags_ready),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .retire_valid(retire_valid), .retire_tag(retire_tag),
        .free_count(free_count)
    );

    function automatic map_t ident();
        map_t m;
        for (int i = 0; i < NL; i++) m[i] = AW'(i);
        return m;
    endfunction

    function automatic logic [NL-1:0] hitv(input map_t m, input logic v, input logic [AW-1:0] t);
        logic [NL-1:0] h;
        h = '0;
        for (int i = 0; i < NL; i++) h[i] = v && (m[i] == t);
        return h;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        phase = P_INIT;
        fq.delete();
        pool.delete();
        for (int i = NL; i < NP; i++) fq.push_back(AW'(i));
        need = '0;
        ren  = '0;
    endtask

    // One clock: check outputs against the model, then advance the model on the edge.
    task automatic cycle();
        logic er, ed, eav, edr;
        map_t ea;
        logic [NL-1:0] ef;
        int k;
        #1;
        er = 0; ed = 0; eav = 0; edr = 0;
        ea = rat_map;
        ef = rat_done | hitv(rat_map, cdb_valid, cdb_tag);
        if (rst_n) begin
            case (phase)
                P_INIT:   begin eav = 1; edr = 1; ea = ident(); ef = '1; end
                P_IDLE:   begin er = 1; edr = cdb_valid; end
                P_ALLOC:  edr = cdb_valid;
                default: begin
                    eav = 1; edr = 1; ed = 1; ea = new_map;
                    ef = (rat_done | hitv(new_map, cdb_valid, cdb_tag)) & ~ren;
                end
            endcase
        end
        obs_rdone = rename_done; obs_av = assignments_valid; obs_dfr = done_flags_ready;
        obs_assign = assignments_in; obs_dfin = done_flags_in; obs_fc = free_count;
        chk("rename_ready", rename_ready, er);
        chk("rename_done", rename_done, ed);
        chk("assignments_valid", assignments_valid, eav);
        chk("done_flags_ready", done_flags_ready, edr);
        chk("free_count", free_count, fq.size());
        if (eav) chk("assignments_in", assignments_in, ea);
        if (edr) chk("done_flags_in", done_flags_in, ef);
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            case (phase)
                P_INIT: begin rat_map = ident(); rat_done = '1; phase = P_IDLE; end
                P_IDLE: begin
                    if (cdb_valid) rat_done = ef;
                    if (rename_valid) begin
                        ren = rename_dests; need = rename_dests; new_map = rat_map; phase = P_ALLOC;
                    end
                end
                P_ALLOC: begin
                    if (cdb_valid) rat_done = ef;
                    if (need == '0) phase = P_COMMIT;
                    else if (fq.size() > 0) begin
                        k = 0;
                        while (!need[k]) k++;
                        new_map[k] = fq.pop_front();
                        need[k] = 1'b0;
                        if (need == '0) phase = P_COMMIT;
                    end
                end
                default: begin
                    for (int i = 0; i < NL; i++) if (ren[i]) pool.push_back(rat_map[i]);
                    rat_done = ef;
                    rat_map  = new_map;
                    phase    = P_IDLE;
                end
            endcase
            if (retire_valid && fq.size() < NP) fq.push_back(retire_tag);
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0; cycle();
        rst_n = 1; cycle();
    endtask

    task automatic do_rename(input logic [NL-1:0] d, output int lat);
        rename_valid = 1; rename_dests = d; cycle();
        rename_valid = 0; rename_dests = '0;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            cycle();
            if (obs_rdone === 1'b1) begin lat = i; break; end
        end
    endtask

    typedef struct {
        logic [NL-1:0] dests;
        int            lat;
        logic [AW-1:0] tag;   // tag given to the lowest renamed LR
        logic [AW:0]   fc;    // free_count during COMMIT
    } vec_t;
    vec_t tbl[5];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, k;
        tbl[0] = '{10'b0000000101, 3, 5'd10, 6'd20};
        tbl[1] = '{10'b0000000000, 2, 5'd0,  6'd20};
        tbl[2] = '{10'b0000001000, 2, 5'd12, 6'd19};
        tbl[3] = '{10'b1000000000, 2, 5'd13, 6'd18};
        tbl[4] = '{10'b0011110000, 5, 5'd14, 6'd14};

        rst_n = 0; rename_valid = 0; rename_dests = '0; cdb_valid = 0; cdb_tag = '0;
        retire_valid = 0; retire_tag = '0; rat_map = '0; rat_done = '0;
        @(posedge clk); #1;
        model_reset();
        cycle(); cycle();
        rst_n = 1;
        cycle();
        chk("init_av", obs_av, 1);
        chk("init_assign", obs_assign, ident());
        chk("init_done", obs_dfin, 10'h3FF);
        chk("init_fc", obs_fc, 22);

        for (int i = 0; i < 5; i++) begin
            do_rename(tbl[i].dests, lat);
            chk("tbl_latency", lat, tbl[i].lat);
            chk("tbl_fc", obs_fc, tbl[i].fc);
            if (tbl[i].dests != '0) begin
                k = 0;
                while (!tbl[i].dests[k]) k++;
                chk("tbl_tag", obs_assign[k], tbl[i].tag);
            end
        end

        // CDB for LR3's tag (12) while idle.
        cdb_valid = 1; cdb_tag = 5'd12; cycle(); cdb_valid = 0;
        chk("idle_cdb_ready", obs_dfr, 1);
        chk("idle_cdb_bit3", obs_dfin[3], 1);

        // CDB on the renamed LR's new tag during COMMIT keeps its done bit clear.
        rename_valid = 1; rename_dests = 10'b0000000010; cycle(); rename_valid = 0;
        for (int i = 0; i < 10; i++) begin
            if (phase == P_COMMIT) begin
                cdb_valid = 1; cdb_tag = new_map[1]; cycle(); cdb_valid = 0;
                chk("commit_cdb_ready", obs_dfr, 1);
                chk("commit_cdb_bit1", obs_dfin[1], 0);
                break;
            end
            cycle();
        end

        // Retire and pop in the same cycle leave the count unchanged.
        rename_valid = 1; rename_dests = 10'b0000000100; cycle(); rename_valid = 0;
        retire_valid = 1; retire_tag = pool.pop_front(); cycle(); retire_valid = 0;
        cycle();
        chk("retire_pop_done", obs_rdone, 1);
        chk("retire_pop_fc", obs_fc, 13);

        // Exhaust the free list, stall, then feed tag 5 back.
        do_reset();
        for (int i = 0; i < 22; i++) begin
            do_rename(NL'(1) << (i % NL), lat);
            chk("exh_latency", lat, 2);
        end
        rename_valid = 1; rename_dests = 10'b0000000001; cycle(); rename_valid = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_no_done", obs_rdone, 0);
        end
        retire_valid = 1; retire_tag = 5'd5; cycle(); retire_valid = 0;
        cycle();
        cycle();
        chk("stall_release_done", obs_rdone, 1);
        chk("stall_release_tag", obs_assign[0], 5);

        // Reset in the middle of ALLOC after one pop.
        do_reset();
        rename_valid = 1; rename_dests = 10'b0000000011; cycle(); rename_valid = 0;
        cycle();
        rst_n = 0; cycle();
        chk("midreset_no_done", obs_rdone, 0);
        chk("midreset_no_av", obs_av, 0);
        rst_n = 1; cycle();
        chk("midreset_init_av", obs_av, 1);
        chk("midreset_fc", obs_fc, 22);

        // Randomised traffic against the model.
        do_reset();
        for (int n = 0; n < 800; n++) begin
            rename_valid = ($urandom_range(0, 2) == 0);
            rename_dests = NL'($urandom);
            cdb_valid    = ($urandom_range(0, 3) == 0);
            cdb_tag      = rat_map[$urandom_range(0, NL-1)];
            retire_valid = 0;
            if (pool.size() > 0 && $urandom_range(0, 2) == 0) begin
                retire_valid = 1;
                retire_tag   = pool.pop_front();
            end
            cycle();
        end
        rename_valid = 0; cdb_valid = 0; retire_valid = 0;
        for (int n = 0; n < 20; n++) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
